// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage: instruction-fetch stage plus the IF/ID pipeline register.
//
// Owns the fetch PC, issues requests on a req/ready instruction-memory port,
// applies redirects coming back from ID (jump has priority over branch),
// honours the hazard-unit stall and hands instruction/pcPlus4/valid to ID.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   stall             : freeze PC and IF/ID; redirect inputs ignored
//   branch_taken/target, jump_taken/target : redirects resolved in ID
//   imem_req/addr     : fetch request, held (address stable) until imem_ready
//   imem_ready/rdata  : request completion and fetched word
//   pc                : current fetch PC
//   instruction, pcPlus4, if_id_valid : IF/ID register contents
//   dbg_state         : FSM state (0 FETCH, 1 KILL, 2 HOLD)
//
// Handshake: a request is outstanding while imem_req=1; it completes in the
// cycle imem_ready=1 (same-cycle ready is allowed). imem_addr does not change
// while imem_req=1 and imem_ready=0, so at most one request is ever in flight.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_taken,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4,
  output logic        if_id_valid,
  output logic [1:0]  dbg_state
);

  // FETCH: request outstanding at pc.
  // KILL : request at the old pc still outstanding but its data is unwanted;
  //        pc moves to the saved target once that request completes.
  // HOLD : fetched word parked in the skid buffer while ID is stalled.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_KILL  = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] saved_tgt_q, saved_tgt_d;

  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redir    = !stall && (jump_taken || branch_taken);
  assign target   = jump_taken ? jump_target : branch_target;
  assign pc_plus4 = pc_q + 32'd4;  // modulo 2^32, FFFF_FFFC wraps to 0

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    saved_tgt_d  = saved_tgt_q;

    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          if (redir) begin
            pc_d    = target;
            instr_d = 32'd0;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
          end else if (stall) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            state_d      = ST_HOLD;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end
        end else begin
          if (redir) begin
            saved_tgt_d = target;
            state_d     = ST_KILL;
          end
          if (!stall) begin
            instr_d = 32'd0;
            pc4_d   = 32'd0;
            valid_d = 1'b0;
          end
        end
      end

      ST_KILL: begin
        if (redir) saved_tgt_d = target;
        if (!stall) begin
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
        end
        if (imem_ready) begin
          // A redirect arriving in the completion cycle is the newest target.
          pc_d    = redir ? target : saved_tgt_q;
          state_d = ST_FETCH;
        end
      end

      ST_HOLD: begin
        if (redir) begin
          pc_d    = target;
          instr_d = 32'd0;
          pc4_d   = 32'd0;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end else if (!stall) begin
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          pc_d    = skid_pc4_q;
          state_d = ST_FETCH;
        end
      end

      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      instr_q      <= 32'd0;
      pc4_q        <= 32'd0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      saved_tgt_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      saved_tgt_q  <= saved_tgt_d;
    end
  end

  assign imem_req    = ((state_q == ST_FETCH) || (state_q == ST_KILL)) && !rst;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign pcPlus4     = pc4_q;
  assign if_id_valid = valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage: directed, table-driven bench for if_stage. Each vector gives
// the inputs for one cycle, the expected request/address before the edge and
// the expected PC, IF/ID contents and state after the edge. The memory model
// returns 32'h2000_0000 | address. Reset cases are hand-written sequences.
// ---------------------------------------------------------------------------
module tb_if_stage;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_taken;
  logic [31:0] jump_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic [31:0] pcPlus4;
  logic        if_id_valid;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump_taken   (jump_taken),
    .jump_target  (jump_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .instruction  (instruction),
    .pcPlus4      (pcPlus4),
    .if_id_valid  (if_id_valid),
    .dbg_state    (dbg_state)
  );

  // Memory model: data word tagged with its address.
  assign imem_rdata = 32'h2000_0000 | imem_addr;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        stall;
    logic        bt;
    logic [31:0] btgt;
    logic        jt;
    logic [31:0] jtgt;
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    logic        exp_valid;
    logic [1:0]  exp_state;
  } vec_t;

  vec_t vecs[$];

  localparam logic [1:0] S_F = 2'd0, S_K = 2'd1, S_H = 2'd2;

  task automatic add(input logic s, input logic bt, input logic [31:0] btgt,
                     input logic jt, input logic [31:0] jtgt, input logic rdy,
                     input logic req, input logic [31:0] addr, input logic [31:0] epc,
                     input logic [31:0] ein, input logic [31:0] ep4, input logic ev,
                     input logic [1:0] est);
    vec_t v;
    v.stall = s; v.bt = bt; v.btgt = btgt; v.jt = jt; v.jtgt = jtgt; v.rdy = rdy;
    v.exp_req = req; v.exp_addr = addr; v.exp_pc = epc; v.exp_instr = ein;
    v.exp_pc4 = ep4; v.exp_valid = ev; v.exp_state = est;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic idle_inputs();
    stall = 0; branch_taken = 0; branch_target = 0;
    jump_taken = 0; jump_target = 0; imem_ready = 0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    string tag;
    @(negedge clk);
    rst = 0;
    stall = v.stall; branch_taken = v.bt; branch_target = v.btgt;
    jump_taken = v.jt; jump_target = v.jtgt; imem_ready = v.rdy;
    #1;
    tag = $sformatf("v%0d", idx);
    check({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, v.exp_req});
    if (v.exp_req) check({tag, " imem_addr"}, imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    check({tag, " pc"}, pc, v.exp_pc);
    check({tag, " instruction"}, instruction, v.exp_instr);
    check({tag, " pcPlus4"}, pcPlus4, v.exp_pc4);
    check({tag, " valid"}, {31'd0, if_id_valid}, {31'd0, v.exp_valid});
    check({tag, " state"}, {30'd0, dbg_state}, {30'd0, v.exp_state});
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1;
    idle_inputs();
    imem_ready = 1;  // stray ready during reset must be ignored
    #1;
    check({tag, " req_in_rst"}, {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, " pc"}, pc, 32'h0);
    check({tag, " instruction"}, instruction, 32'h0);
    check({tag, " pcPlus4"}, pcPlus4, 32'h0);
    check({tag, " valid"}, {31'd0, if_id_valid}, 32'd0);
    check({tag, " state"}, {30'd0, dbg_state}, {30'd0, S_F});
  endtask

  // ---------------- test ----------------
  initial begin
    rst = 1;
    idle_inputs();
    do_reset("rst0");
    do_reset("rst1");

    //   st bt btgt          jt jtgt      rdy req addr          pc            instr         pc4           v  state
    // zero-wait streaming
    add(0, 0, 0,            0, 0,         1,  1, 32'h0,        32'h4,        32'h2000_0000, 32'h4,       1, S_F);
    add(0, 0, 0,            0, 0,         1,  1, 32'h4,        32'h8,        32'h2000_0004, 32'h8,       1, S_F);
    add(0, 0, 0,            0, 0,         1,  1, 32'h8,        32'hC,        32'h2000_0008, 32'hC,       1, S_F);
    // ready every third cycle
    add(0, 0, 0,            0, 0,         0,  1, 32'hC,        32'hC,        32'h0,         32'h0,       0, S_F);
    add(0, 0, 0,            0, 0,         0,  1, 32'hC,        32'hC,        32'h0,         32'h0,       0, S_F);
    add(0, 0, 0,            0, 0,         1,  1, 32'hC,        32'h10,       32'h2000_000C, 32'h10,      1, S_F);
    // branch with ready fetch at 0x10
    add(0, 1, 32'h40,       0, 0,         1,  1, 32'h10,       32'h40,       32'h0,         32'h0,       0, S_F);
    add(0, 0, 0,            0, 0,         1,  1, 32'h40,       32'h44,       32'h2000_0040, 32'h44,      1, S_F);
    // jump while fetch waits -> KILL, late data discarded
    add(0, 0, 0,            1, 32'h100,   0,  1, 32'h44,       32'h44,       32'h0,         32'h0,       0, S_K);
    add(0, 0, 0,            0, 0,         0,  1, 32'h44,       32'h44,       32'h0,         32'h0,       0, S_K);
    add(0, 0, 0,            0, 0,         1,  1, 32'h44,       32'h100,      32'h0,         32'h0,       0, S_F);
    add(0, 0, 0,            0, 0,         1,  1, 32'h100,      32'h104,      32'h2000_0100, 32'h104,     1, S_F);
    // stall with ready fetch -> HOLD for 4 cycles, then release
    add(1, 0, 0,            0, 0,         1,  1, 32'h104,      32'h104,      32'h2000_0100, 32'h104,     1, S_H);
    add(1, 0, 0,            0, 0,         1,  0, 32'h0,        32'h104,      32'h2000_0100, 32'h104,     1, S_H);
    add(1, 0, 0,            0, 0,         1,  0, 32'h0,        32'h104,      32'h2000_0100, 32'h104,     1, S_H);
    add(1, 0, 0,            0, 0,         1,  0, 32'h0,        32'h104,      32'h2000_0100, 32'h104,     1, S_H);
    add(0, 0, 0,            0, 0,         0,  0, 32'h0,        32'h108,      32'h2000_0104, 32'h108,     1, S_F);
    // branch during stall is ignored; IF/ID holds while waiting
    add(1, 1, 32'h200,      0, 0,         0,  1, 32'h108,      32'h108,      32'h2000_0104, 32'h108,     1, S_F);
    add(0, 0, 0,            0, 0,         1,  1, 32'h108,      32'h10C,      32'h2000_0108, 32'h10C,     1, S_F);
    // redirect in KILL overwrites saved target (jump 0x300, then branch 0x400)
    add(0, 0, 0,            1, 32'h300,   0,  1, 32'h10C,      32'h10C,      32'h0,         32'h0,       0, S_K);
    add(0, 1, 32'h400,      0, 0,         0,  1, 32'h10C,      32'h10C,      32'h0,         32'h0,       0, S_K);
    add(0, 0, 0,            0, 0,         1,  1, 32'h10C,      32'h400,      32'h0,         32'h0,       0, S_F);
    // jump wins over branch in the same cycle
    add(0, 1, 32'h700,      1, 32'h404,   1,  1, 32'h400,      32'h404,      32'h0,         32'h0,       0, S_F);
    // PC wrap at FFFF_FFFC
    add(0, 1, 32'hFFFF_FFFC,0, 0,         1,  1, 32'h404,      32'hFFFF_FFFC,32'h0,         32'h0,       0, S_F);
    add(0, 0, 0,            0, 0,         1,  1, 32'hFFFF_FFFC,32'h0,        32'hFFFF_FFFC, 32'h0,       1, S_F);
    // redirect out of HOLD drops the skid buffer
    add(1, 0, 0,            0, 0,         1,  1, 32'h0,        32'h0,        32'hFFFF_FFFC, 32'h0,       1, S_H);
    add(0, 0, 0,            1, 32'h500,   0,  0, 32'h0,        32'h500,      32'h0,         32'h0,       0, S_F);
    add(0, 0, 0,            0, 0,         1,  1, 32'h500,      32'h504,      32'h2000_0500, 32'h504,     1, S_F);
    // enter KILL, stall inside it, leave waiting for reset
    add(0, 0, 0,            1, 32'h600,   0,  1, 32'h504,      32'h504,      32'h0,         32'h0,       0, S_K);
    add(1, 0, 0,            0, 0,         0,  1, 32'h504,      32'h504,      32'h0,         32'h0,       0, S_K);

    foreach (vecs[i]) apply(vecs[i], i);

    // reset asserted during KILL
    do_reset("rst_kill");

    // after reset: fetch restarts at RESET_PC, not at the saved target 0x600
    begin
      vec_t v;
      v.stall = 0; v.bt = 0; v.btgt = 0; v.jt = 0; v.jtgt = 0; v.rdy = 1;
      v.exp_req = 1; v.exp_addr = 32'h0; v.exp_pc = 32'h4;
      v.exp_instr = 32'h2000_0000; v.exp_pc4 = 32'h4; v.exp_valid = 1; v.exp_state = S_F;
      apply(v, 100);
      v.exp_addr = 32'h4; v.exp_pc = 32'h8; v.exp_instr = 32'h2000_0004; v.exp_pc4 = 32'h8;
      apply(v, 101);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
